// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - game state machine and shared phase-locked motion strobes
module game_tick_scheduler #(
  parameter int BASE_W    = 9,
  parameter int HOLD_W    = 4,
  parameter int OVER_HOLD = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause_btn,
  input  logic collide,
  output logic running,
  output logic paused,
  output logic game_over,
  output logic clear_field,
  output logic grav_tick,
  output logic pipe_tick,
  output logic spawn_tick
);

  localparam int CW = BASE_W + 2;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              live;

  // Strobes are decoded from registered state so they stay phase-locked to cnt.
  assign live       = (state == RUN) && !collide;
  assign grav_tick  = live && (&cnt[BASE_W-1:0]);
  assign pipe_tick  = live && (&cnt[BASE_W:0]);
  assign spawn_tick = live && (&cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      running     <= 1'b0;
      paused      <= 1'b0;
      game_over   <= 1'b0;
      clear_field <= 1'b0;
    end else begin
      clear_field <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          hold_cnt <= '0;
          if (start) begin
            state       <= RUN;
            running     <= 1'b1;
            clear_field <= 1'b1;
          end
        end
        RUN: begin
          if (collide) begin
            state     <= OVER;
            cnt       <= '0;
            hold_cnt  <= '0;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (pause_btn) begin
              state   <= PAUSED;
              running <= 1'b0;
              paused  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (pause_btn) begin
            state   <= RUN;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        OVER: begin
          // cnt doubles as the lockout divider; hold_cnt counts its low-field rollovers.
          cnt <= cnt + CNT_ONE;
          if ((&cnt[BASE_W-1:0]) && (hold_cnt < HOLD_MAX))
            hold_cnt <= hold_cnt + HOLD_ONE;
          if (start && (hold_cnt == HOLD_MAX)) begin
            state       <= RUN;
            cnt         <= '0;
            hold_cnt    <= '0;
            running     <= 1'b1;
            game_over   <= 1'b0;
            clear_field <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
